// File: rtl/hazard3_shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with valid/ready handshakes and tag passthrough.
// Define HAZARD3_SHIFT_PIPE_ROTATE_EN for true ROL/ROR; otherwise they execute as SLL/SRL.
module hazard3_shift_pipe #(
    parameter int unsigned W_DATA   = 32,
    parameter int unsigned W_SHAMT  = $clog2(W_DATA),
    parameter int unsigned N_STAGES = 2,
    parameter int unsigned W_TAG    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W_DATA-1:0]  in_data,
    input  logic [W_SHAMT-1:0] in_shamt,
    input  logic [2:0]         in_op,
    input  logic [W_TAG-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W_DATA-1:0]  out_data,
    output logic [W_TAG-1:0]   out_tag
);

    localparam logic [2:0] OpSra = 3'd2;
    localparam logic [2:0] OpSrl = 3'd1;
    localparam logic [2:0] OpRol = 3'd3;
    localparam logic [2:0] OpRor = 3'd4;

    function automatic logic [W_DATA-1:0] bit_rev(input logic [W_DATA-1:0] x);
        logic [W_DATA-1:0] r;
        for (int i = 0; i < W_DATA; i++) begin
            r[i] = x[W_DATA-1-i];
        end
        return r;
    endfunction

    function automatic logic is_right(input logic [2:0] op);
        return (op == OpSrl) || (op == OpSra) || (op == OpRor);
    endfunction

`ifdef HAZARD3_SHIFT_PIPE_ROTATE_EN
    function automatic logic is_rot(input logic [2:0] op);
        return (op == OpRol) || (op == OpRor);
    endfunction
`endif

    // Applies the shift layers that belong to stage k; right ops arrive pre-reversed.
    function automatic logic [W_DATA-1:0] layers(
        input int unsigned        k,
        input logic [W_DATA-1:0]  x,
        input logic [W_SHAMT-1:0] sh,
        input logic               fill
`ifdef HAZARD3_SHIFT_PIPE_ROTATE_EN
        ,
        input logic               rot
`endif
    );
        logic [W_DATA-1:0] y;
        y = x;
        for (int unsigned i = 0; i < W_SHAMT; i++) begin
            if (((i * N_STAGES) / W_SHAMT) == k && sh[i]) begin
`ifdef HAZARD3_SHIFT_PIPE_ROTATE_EN
                if (rot) y = (y << (1 << i)) | (y >> (W_DATA - (1 << i)));
                else
`endif
                y = (y << (1 << i)) | ({W_DATA{fill}} >> (W_DATA - (1 << i)));
            end
        end
        return y;
    endfunction

    logic [N_STAGES-1:0] valid_q;
    logic [W_DATA-1:0]   data_q  [N_STAGES];
    logic [W_SHAMT-1:0]  shamt_q [N_STAGES];
    logic [2:0]          op_q    [N_STAGES];
    logic [W_TAG-1:0]    tag_q   [N_STAGES];
    logic                fill_q  [N_STAGES];

    logic [N_STAGES-1:0] ready;
    logic                ready_acc;

    logic [N_STAGES-1:0] src_valid;
    logic [W_DATA-1:0]   src_data  [N_STAGES];
    logic [W_SHAMT-1:0]  src_shamt [N_STAGES];
    logic [2:0]          src_op    [N_STAGES];
    logic [W_TAG-1:0]    src_tag   [N_STAGES];
    logic                src_fill  [N_STAGES];
    logic [W_DATA-1:0]   nxt_data  [N_STAGES];

    // ready[k]: stage k can load this cycle (empty, or its content moves on).
    always_comb begin
        ready     = '0;
        ready_acc = out_ready;
        for (int k = N_STAGES - 1; k >= 0; k--) begin
            ready_acc = !valid_q[k] || ready_acc;
            ready[k]  = ready_acc;
        end
    end

    assign in_ready = !flush && ready[0];

    always_comb begin
        src_valid[0] = in_valid && in_ready;
        src_data[0]  = is_right(in_op) ? bit_rev(in_data) : in_data;
        src_shamt[0] = in_shamt;
        src_op[0]    = in_op;
        src_tag[0]   = in_tag;
        src_fill[0]  = (in_op == OpSra) && in_data[W_DATA-1];
        for (int k = 1; k < N_STAGES; k++) begin
            src_valid[k] = valid_q[k-1];
            src_data[k]  = data_q[k-1];
            src_shamt[k] = shamt_q[k-1];
            src_op[k]    = op_q[k-1];
            src_tag[k]   = tag_q[k-1];
            src_fill[k]  = fill_q[k-1];
        end
        for (int k = 0; k < N_STAGES; k++) begin
`ifdef HAZARD3_SHIFT_PIPE_ROTATE_EN
            nxt_data[k] = layers(k, src_data[k], src_shamt[k], src_fill[k], is_rot(src_op[k]));
`else
            nxt_data[k] = layers(k, src_data[k], src_shamt[k], src_fill[k]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < N_STAGES; k++) begin
                data_q[k]  <= '0;
                shamt_q[k] <= '0;
                op_q[k]    <= '0;
                tag_q[k]   <= '0;
                fill_q[k]  <= 1'b0;
            end
        end else begin
            for (int k = 0; k < N_STAGES; k++) begin
                if (flush) begin
                    valid_q[k] <= 1'b0;
                end else if (ready[k]) begin
                    valid_q[k] <= src_valid[k];
                end
                // Payload only moves with a real op so a stalled result never changes.
                if (ready[k] && src_valid[k]) begin
                    data_q[k]  <= nxt_data[k];
                    shamt_q[k] <= src_shamt[k];
                    op_q[k]    <= src_op[k];
                    tag_q[k]   <= src_tag[k];
                    fill_q[k]  <= src_fill[k];
                end
            end
        end
    end

    assign out_valid = valid_q[N_STAGES-1];
    assign out_tag   = tag_q[N_STAGES-1];
    assign out_data  = is_right(op_q[N_STAGES-1]) ? bit_rev(data_q[N_STAGES-1])
                                                  : data_q[N_STAGES-1];

endmodule

// File: tb/tb_hazard3_shift_pipe.sv
// Scoreboard bench for hazard3_shift_pipe: directed cases at 32/2 plus random sweeps of width and depth.
module tb_hazard3_shift_pipe;

    localparam int NS = 2;
`ifdef HAZARD3_SHIFT_PIPE_ROTATE_EN
    localparam bit RotEn = 1'b1;
`else
    localparam bit RotEn = 1'b0;
`endif

    typedef struct {
        logic [63:0] data;
        logic [7:0]  tag;
        int          cyc;
        bit          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int sw_done = 0;
    int rdy_mode = 1;
    always @(posedge clk) cyc++;

    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [4:0]  in_shamt = '0;
    logic [2:0]  in_op = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [4:0]  out_tag;

    exp_t sb[$];

    hazard3_shift_pipe #(.W_DATA(32), .N_STAGES(NS), .W_TAG(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
    );

    // Reference: plain arithmetic on a w-bit value held in 64 bits.
    function automatic logic [63:0] ref_shift(input logic [63:0] din, input int s,
                                              input logic [2:0] op, input int w);
        logic [63:0] m, d, r;
        logic neg;
        m = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        d = din & m;
        neg = d[w-1];
        case (op)
            3'd1: r = d >> s;
            3'd2: r = (d >> s) | (neg ? (m & ~(m >> s)) : 64'd0);
            3'd3: r = !RotEn ? (d << s) : (s == 0) ? d : ((d << s) | (d >> (w - s)));
            3'd4: r = !RotEn ? (d >> s) : (s == 0) ? d : ((d >> s) | (d << (w - s)));
            default: r = d << s;
        endcase
        return r & m;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // out_ready driver: 0 = low, 1 = high, 2 = random.
    initial forever begin
        @(posedge clk);
        #2;
        out_ready = (rdy_mode == 0) ? 1'b0 : (rdy_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got tag 0x%0h, expected no result", out_tag);
                end else begin
                    check("out_data", 64'(out_data), sb[0].data);
                    check("out_tag", 64'(out_tag), 64'(sb[0].tag));
                    if (out_ready) begin
                        if (sb[0].lat) check("latency", 64'(cyc - sb[0].cyc), 64'(NS));
                        void'(sb.pop_front());
                    end
                end
            end
            // The result transferring this cycle was popped above; the rest are discarded.
            if (flush) sb.delete();
        end
    end

    task automatic push_exp(input logic [31:0] exp, input logic [4:0] tag);
        exp_t e;
        e.data = 64'(exp);
        e.tag  = 8'(tag);
        e.cyc  = cyc;
        e.lat  = (rdy_mode == 1);
        sb.push_back(e);
    endtask

    task automatic issue(input logic [31:0] d, input logic [4:0] sh, input logic [2:0] op,
                         input logic [4:0] tag, input logic [31:0] exp);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = sh;
        in_op    = op;
        in_tag   = tag;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                push_exp(exp, tag);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        in_valid = 1'b0;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got no accept for tag 0x%0h, expected accept", tag);
        end
    endtask

    task automatic rnd_issue(input logic [4:0] tag);
        logic [31:0] d;
        logic [4:0]  sh;
        logic [2:0]  op;
        logic [63:0] e;
        d  = $urandom;
        sh = 5'($urandom_range(0, 31));
        op = 3'($urandom_range(0, 7));
        e  = ref_shift(64'(d), int'(sh), op, 32);
        issue(d, sh, op, tag, e[31:0]);
    endtask

    task automatic drain(input int limit);
        bit empty;
        empty = 1'b0;
        for (int t = 0; t < limit; t++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                empty = 1'b1;
                break;
            end
        end
        if (!empty) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d results outstanding, expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    logic [31:0] bp_d   [7];
    logic [4:0]  bp_sh  [7];
    logic [2:0]  bp_op  [7];
    logic [31:0] bp_exp [7];

    initial begin
        int k;
        int acc;
        logic [63:0] e;
        @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed basic ops
        issue(32'h8000_0000, 5'd4, 3'd2, 5'd1, 32'hF800_0000);
        issue(32'h0000_0001, 5'd31, 3'd0, 5'd2, 32'h8000_0000);
        issue(32'hFFFF_FFFF, 5'd0, 3'd1, 5'd3, 32'hFFFF_FFFF);
        issue(32'h0000_0001, 5'd1, 3'd4, 5'd4, RotEn ? 32'h8000_0000 : 32'h0);
        issue(32'h8000_0000, 5'd1, 3'd3, 5'd5, RotEn ? 32'h0000_0001 : 32'h0);
        issue(32'h0000_0001, 5'd3, 3'd7, 5'd6, 32'h0000_0008);
        issue(32'h8000_0000, 5'd31, 3'd2, 5'd7, 32'hFFFF_FFFF);
        drain(50);

        // Backpressure: tags 1..6 with out_ready held low for 5 cycles
        for (int i = 1; i <= 6; i++) begin
            bp_d[i]  = $urandom;
            bp_sh[i] = 5'($urandom_range(0, 31));
            bp_op[i] = 3'($urandom_range(0, 4));
            e = ref_shift(64'(bp_d[i]), int'(bp_sh[i]), bp_op[i], 32);
            bp_exp[i] = e[31:0];
        end
        rdy_mode = 0;
        k = 1;
        acc = 0;
        in_valid = 1'b1;
        in_data = bp_d[1];
        in_shamt = bp_sh[1];
        in_op = bp_op[1];
        in_tag = 5'd1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (in_ready) begin
                push_exp(bp_exp[k], 5'(k));
                k++;
                acc++;
            end
            @(posedge clk);
            #1;
            in_data = bp_d[k];
            in_shamt = bp_sh[k];
            in_op = bp_op[k];
            in_tag = 5'(k);
        end
        check("bp_accepts", 64'(acc), 64'(NS));
        @(negedge clk);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rdy_mode = 1;
        for (; k <= 6; k++) issue(bp_d[k], bp_sh[k], bp_op[k], 5'(k), bp_exp[k]);
        drain(50);

        // Flush with tags 1,2 in flight and tag 3 offered
        rdy_mode = 0;
        rnd_issue(5'd1);
        rnd_issue(5'd2);
        in_valid = 1'b1;
        in_data = 32'h1234_5678;
        in_tag = 5'd3;
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        rdy_mode = 1;
        issue(32'h0000_00F0, 5'd4, 3'd1, 5'd4, 32'h0000_000F);
        drain(50);

        // Reset with two ops in flight
        rdy_mode = 0;
        rnd_issue(5'd9);
        rnd_issue(5'd10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data", 64'(out_data), 64'd0);
        check("midrst_out_tag", 64'(out_tag), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rdy_mode = 1;
        repeat (5) @(posedge clk);
        #1;
        issue(32'h0000_0003, 5'd2, 3'd0, 5'd11, 32'h0000_000C);
        drain(50);

        // Random ops with random consumer stalls
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end else begin
                rnd_issue(5'(i));
            end
        end
        drain(400);
        rdy_mode = 1;

        for (int t = 0; t < 5000 && sw_done < 6; t++) @(posedge clk);
        if (sw_done < 6) begin
            tests++;
            fails++;
            $display("FAIL sweep_timeout: got %0d sweeps done, expected 6", sw_done);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Width/depth sweep, consumer always ready, latency checked on every result
    for (genvar g = 0; g < 6; g++) begin : g_sweep
        localparam int SW  = (g < 3) ? 32 : 64;
        localparam int SN  = (g % 3 == 0) ? 1 : (g % 3 == 1) ? 3 : 5;
        localparam int SWS = $clog2(SW);

        logic           s_rst = 1'b1;
        logic           s_in_valid = 1'b0;
        logic           s_in_ready;
        logic [SW-1:0]  s_in_data = '0;
        logic [SWS-1:0] s_in_shamt = '0;
        logic [2:0]     s_in_op = '0;
        logic [4:0]     s_in_tag = '0;
        logic           s_out_valid;
        logic [SW-1:0]  s_out_data;
        logic [4:0]     s_out_tag;
        exp_t           q[$];

        hazard3_shift_pipe #(.W_DATA(SW), .N_STAGES(SN), .W_TAG(5)) s_dut (
            .clk(clk), .rst(s_rst), .flush(1'b0),
            .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
            .in_shamt(s_in_shamt), .in_op(s_in_op), .in_tag(s_in_tag),
            .out_valid(s_out_valid), .out_ready(1'b1), .out_data(s_out_data),
            .out_tag(s_out_tag)
        );

        always @(negedge clk) begin
            if (!s_rst && s_out_valid) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sweep_unexpected: got tag 0x%0h in sweep %0d, expected none",
                             s_out_tag, g);
                end else begin
                    check("sweep_data", 64'(s_out_data), q[0].data);
                    check("sweep_tag", 64'(s_out_tag), 64'(q[0].tag));
                    check("sweep_latency", 64'(cyc - q[0].cyc), 64'(SN));
                    void'(q.pop_front());
                end
            end
        end

        initial begin
            exp_t e;
            repeat (3) @(posedge clk);
            #1;
            s_rst = 1'b0;
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, 4) == 0) begin
                    s_in_valid = 1'b0;
                end else begin
                    s_in_valid = 1'b1;
                    s_in_data  = SW'({$urandom, $urandom});
                    s_in_shamt = SWS'($urandom_range(0, SW - 1));
                    s_in_op    = 3'($urandom_range(0, 7));
                    s_in_tag   = 5'(i);
                end
                @(negedge clk);
                if (s_in_valid) begin
                    check("sweep_in_ready", 64'(s_in_ready), 64'd1);
                    e.data = ref_shift(64'(s_in_data), int'(s_in_shamt), s_in_op, SW);
                    e.tag  = 8'(s_in_tag);
                    e.cyc  = cyc;
                    e.lat  = 1'b1;
                    q.push_back(e);
                end
                @(posedge clk);
                #1;
            end
            s_in_valid = 1'b0;
            for (int t = 0; t < 50 && q.size() != 0; t++) @(posedge clk);
            if (q.size() != 0) begin
                tests++;
                fails++;
                $display("FAIL sweep_drain: got %0d outstanding in sweep %0d, expected 0",
                         q.size(), g);
            end
            sw_done++;
        end
    end

endmodule
